// File: rtl/bullcow_display_if.sv
// Signal bundle between the Bulls & Cows game FSM (master) and the 7-segment display driver (slave).
// The link is free-running with no handshake: the display samples the game outputs every clock.
interface bullcow_display_if;
    logic [2:0]  game_state;
    logic        guess_confirmed;
    logic [2:0]  bull_count;
    logic [2:0]  cow_count;
    logic [7:0]  J1_points;
    logic [7:0]  J2_points;
    logic [15:0] SW;
    logic [7:0]  an;
    logic [7:0]  seg;

    modport master (
        output game_state, guess_confirmed, bull_count, cow_count, J1_points, J2_points, SW,
        input  an, seg
    );

    modport slave (
        input  game_state, guess_confirmed, bull_count, cow_count, J1_points, J2_points, SW,
        output an, seg
    );
endinterface

// File: rtl/bullcow_display.sv
// 8-digit multiplexed 7-segment driver for the Bulls & Cows game (prompt, switches, result, score).
// Optional END_GAME blinking is compiled in with the BULLCOW_DISP_BLINK_EN macro.
module bullcow_display #(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLINK_DIV   = 25_000_000
) (
    input  logic             clock,
    input  logic             reset,
    bullcow_display_if.slave bus
);
    typedef enum logic [2:0] {
        J1_SETUP = 3'b000,
        J2_SETUP = 3'b001,
        J1_GUESS = 3'b010,
        J2_GUESS = 3'b011,
        END_GAME = 3'b111
    } game_state_e;

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

    // Active-high {g,f,e,d,c,b,a} patterns for the non-hex glyphs.
    localparam logic [6:0] GLYPH_J     = 7'h1E;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h58;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = GLYPH_B;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [2:0]    prev_state_q;
    logic          res_valid_q, res_valid_d;
    logic [2:0]    res_bull_q, res_bull_d;
    logic [2:0]    res_cow_q, res_cow_d;
    logic [6:0]    pattern;
    logic [3:0]    sw_nibble;
    game_state_e   state;

    assign state = game_state_e'(bus.game_state);

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + 1'b1;
        digit_idx_d   = digit_idx_q;
        if (refresh_cnt_q == REFRESH_LAST) begin
            refresh_cnt_d = '0;
            digit_idx_d   = digit_idx_q + 3'd1;
        end
    end

    always_comb begin
        case (digit_idx_q[1:0])
            2'd0:    sw_nibble = bus.SW[3:0];
            2'd1:    sw_nibble = bus.SW[7:4];
            2'd2:    sw_nibble = bus.SW[11:8];
            default: sw_nibble = bus.SW[15:12];
        endcase
    end

    // Setup and guess screens share the "J<player> .. SW" frame; only d5/d4 differ.
    always_comb begin
        pattern = GLYPH_DASH;
        case (state)
            J1_SETUP, J2_SETUP, J1_GUESS, J2_GUESS: begin
                case (digit_idx_q)
                    3'd7: pattern = GLYPH_J;
                    3'd6: pattern = hex_glyph(bus.game_state[0] ? 4'h2 : 4'h1);
                    3'd5: pattern = (bus.game_state[1] && res_valid_q) ? hex_glyph({1'b0, res_bull_q}) : GLYPH_BLANK;
                    3'd4: pattern = (bus.game_state[1] && res_valid_q) ? hex_glyph({1'b0, res_cow_q}) : GLYPH_BLANK;
                    default: pattern = hex_glyph(sw_nibble);
                endcase
            end
            END_GAME: begin
                case (digit_idx_q)
                    3'd7:    pattern = hex_glyph(bus.J1_points[7:4]);
                    3'd6:    pattern = hex_glyph(bus.J1_points[3:0]);
                    3'd1:    pattern = hex_glyph(bus.J2_points[7:4]);
                    3'd0:    pattern = hex_glyph(bus.J2_points[3:0]);
                    default: pattern = GLYPH_DASH;
                endcase
            end
            default: pattern = GLYPH_DASH;
        endcase
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_bull_d  = res_bull_q;
        res_cow_d   = res_cow_q;
        if ((bus.game_state != prev_state_q) && bus.guess_confirmed) begin
            res_valid_d = 1'b1;
            res_bull_d  = bus.bull_count;
            res_cow_d   = bus.cow_count;
        end
        if (state == J1_SETUP) res_valid_d = 1'b0;
    end

    assign seg_d = {1'b1, ~pattern};

`ifdef BULLCOW_DISP_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (state == END_GAME) begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            blink_on_d  = blink_on_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end
        end
    end

    assign an_d = blink_on_q ? ~(8'h01 << digit_idx_q) : 8'hFF;

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`else
    // Blinking is compiled out, so BLINK_DIV has no effect in this build.
    localparam int unsigned blink_div_unused = BLINK_DIV;

    assign an_d = ~(8'h01 << digit_idx_q);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= 3'd0;
            an_q          <= 8'hFF;
            seg_q         <= 8'hFF;
            prev_state_q  <= 3'b000;
            res_valid_q   <= 1'b0;
            res_bull_q    <= 3'd0;
            res_cow_q     <= 3'd0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            prev_state_q  <= bus.game_state;
            res_valid_q   <= res_valid_d;
            res_bull_q    <= res_bull_d;
            res_cow_q     <= res_cow_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
endmodule

// File: tb/tb_bullcow_display.sv
// Bench for bullcow_display: directed screens plus random game inputs, every cycle compared
// against a reference built from the display rules (scan position from elapsed cycles, digit map table).
module tb_bullcow_display;
  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bullcow_display_if bus ();

  bullcow_display #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Active-high {g,f,e,d,c,b,a} glyph patterns.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [6:0] G_J    = 7'h1E;
  localparam logic [6:0] G_DASH = 7'h40;

  int total = 0;
  int bad   = 0;
  int n     = 0;          // active edges since reset release
  logic [7:0] exp_an, exp_seg;
  logic [2:0] m_prev;
  logic       m_rv;
  logic [2:0] m_rb, m_rc;
  int         m_bcnt;
  logic       m_bon;

  function automatic logic [7:0] model_seg(input int d);
    logic [6:0] p;
    logic [2:0] st;
    logic [3:0] v;
    st = bus.game_state;
    p  = G_DASH;
    if (st[2] == 1'b0) begin
      if (d == 7) p = G_J;
      else if (d == 6) begin
        v = st[0] ? 4'd2 : 4'd1;
        p = hex_tab[v];
      end else if (d >= 4) begin
        v = (d == 5) ? {1'b0, m_rb} : {1'b0, m_rc};
        p = (st[1] && m_rv) ? hex_tab[v] : 7'h00;
      end else begin
        v = bus.SW[d*4 +: 4];
        p = hex_tab[v];
      end
    end else if (st == 3'b111) begin
      if (d == 7) p = hex_tab[bus.J1_points[7:4]];
      else if (d == 6) p = hex_tab[bus.J1_points[3:0]];
      else if (d == 1) p = hex_tab[bus.J2_points[7:4]];
      else if (d == 0) p = hex_tab[bus.J2_points[3:0]];
    end
    return {1'b1, ~p};
  endfunction

  task automatic tick(input string tag);
    int d;
    @(posedge clock);
    if (reset) begin
      exp_an = 8'hFF; exp_seg = 8'hFF; n = 0;
      m_prev = 3'b000; m_rv = 1'b0; m_rb = 3'd0; m_rc = 3'd0;
      m_bcnt = 0; m_bon = 1'b1;
    end else begin
      n++;
      d = ((n - 1) / REFRESH_DIV) % 8;
      exp_an  = ~(8'h01 << d);
      exp_seg = model_seg(d);
`ifdef BULLCOW_DISP_BLINK_EN
      if (!m_bon) exp_an = 8'hFF;
      if (bus.game_state == 3'b111) begin
        if (m_bcnt == BLINK_DIV - 1) begin m_bcnt = 0; m_bon = !m_bon; end
        else m_bcnt++;
      end else begin
        m_bcnt = 0; m_bon = 1'b1;
      end
`endif
      if (bus.game_state != m_prev && bus.guess_confirmed) begin
        m_rv = 1'b1; m_rb = bus.bull_count; m_rc = bus.cow_count;
      end
      if (bus.game_state == 3'b000) m_rv = 1'b0;
      m_prev = bus.game_state;
    end
    @(negedge clock);
    total++;
    assert (bus.an === exp_an) else begin
      bad++;
      $error("FAIL %s an n=%0d got=%h want=%h", tag, n, bus.an, exp_an);
    end
    total++;
    assert (bus.seg === exp_seg) else begin
      bad++;
      $error("FAIL %s seg n=%0d an=%h got=%h want=%h", tag, n, bus.an, bus.seg, exp_seg);
    end
  endtask

  task automatic run(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) tick(tag);
  endtask

  initial begin
    bus.game_state = 3'b000; bus.guess_confirmed = 1'b0;
    bus.bull_count = 3'd0;   bus.cow_count = 3'd0;
    bus.J1_points = 8'h00;   bus.J2_points = 8'h00;
    bus.SW = 16'h0000;

    reset = 1'b1;
    run(3, "reset");
    reset = 1'b0;

    bus.SW = 16'h1234;
    run(40, "setup_j1");

    bus.game_state = 3'b001; bus.SW = 16'hABCF;
    run(34, "setup_j2");

    bus.game_state = 3'b010;
    run(6, "guess_j1_empty");
    bus.game_state = 3'b011; bus.guess_confirmed = 1'b1; bus.bull_count = 3'd2; bus.cow_count = 3'd1;
    run(1, "capture");
    bus.guess_confirmed = 1'b0; bus.bull_count = 3'd4; bus.cow_count = 3'd3;
    run(36, "guess_held");
    bus.guess_confirmed = 1'b1;
    run(33, "confirm_no_change");
    bus.guess_confirmed = 1'b0; bus.game_state = 3'b000;
    run(34, "setup_clear");

    bus.game_state = 3'b111; bus.J1_points = 8'h0A; bus.J2_points = 8'h03;
    run(40, "end_game");

    bus.game_state = 3'b100;
    run(34, "other_code");

    for (int k = 0; k < 30; k++) begin
      bus.game_state      = 3'($urandom_range(0, 7));
      bus.guess_confirmed = 1'($urandom_range(0, 1));
      bus.bull_count      = 3'($urandom_range(0, 4));
      bus.cow_count       = 3'($urandom_range(0, 4));
      bus.J1_points       = 8'($urandom);
      bus.J2_points       = 8'($urandom);
      bus.SW              = 16'($urandom);
      run($urandom_range(1, 12), "random");
    end

    reset = 1'b1;
    run(2, "mid_reset");
    reset = 1'b0;
    bus.game_state = 3'b011; bus.guess_confirmed = 1'b0;
    run(12, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
